// File: rtl/arrow_note_queue.sv
// Packs the serial random stream into 4-bit arrow chords {left, down, up, right},
// filters out chords with too many arrows or immediate repeats, and queues the rest.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | shift one random bit per enabled clock into cand
// FILTER  | one cycle: reject (note_dropped) or accept the candidate
// PUSH    | write cand into the FIFO; stall here while full and not popping
module arrow_note_queue #(
    parameter int DEPTH      = 8,
    parameter int MAX_ARROWS = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   random,
    input  logic                   enable,
    input  logic                   note_pop,
    output logic                   note_valid,
    output logic [3:0]             note_arrows,
    output logic [$clog2(DEPTH):0] note_count,
    output logic                   note_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {COLLECT, FILTER, PUSH} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cand;
    logic [3:0]    last;
    logic [1:0]    bit_cnt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [3:0]    mem [DEPTH];
    logic [2:0]    ones;
    logic          reject;
    logic          do_pop;
    logic          do_write;

    assign ones   = {2'b00, cand[0]} + {2'b00, cand[1]} + {2'b00, cand[2]} + {2'b00, cand[3]};
    // The rest chord never counts as a repeat, and it never becomes `last`.
    assign reject = (ones > 3'(MAX_ARROWS)) || ((cand != 4'd0) && (cand == last));
    assign do_pop = note_pop && note_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= COLLECT;
        else          state <= state_nxt;
    end

    // note_dropped is combinational: high for exactly the FILTER cycle that rejects.
    always_comb begin
        state_nxt    = state;
        note_dropped = 1'b0;
        do_write     = 1'b0;
        case (state)
            COLLECT: if (enable && bit_cnt == 2'd3) state_nxt = FILTER;
            FILTER: begin
                if (reject) begin
                    note_dropped = 1'b1;
                    state_nxt    = COLLECT;
                end else begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                if ((count < DEPTH_C) || do_pop) begin
                    do_write  = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand    <= 4'd0;
            bit_cnt <= 2'd0;
            last    <= 4'd0;
        end else begin
            if (state == COLLECT && enable) begin
                cand    <= {cand[2:0], random};
                bit_cnt <= bit_cnt + 2'd1;
            end
            if (do_write && cand != 4'd0) last <= cand;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_write && do_pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= cand;
    end

    assign note_valid  = (count != '0);
    assign note_arrows = note_valid ? mem[rd_ptr] : 4'd0;
    assign note_count  = count;
endmodule

// File: tb/tb_arrow_note_queue.sv
// Bench for arrow_note_queue: chord-level stimulus with a queue-based reference
// model; a separate monitor compares the FIFO head against the scoreboard.
module tb_arrow_note_queue;
    localparam int DEPTH = 8;
    localparam int MAXA  = 2;

    logic                   clk;
    logic                   reset_n;
    logic                   random;
    logic                   enable;
    logic                   note_pop;
    logic                   note_valid;
    logic [3:0]             note_arrows;
    logic [$clog2(DEPTH):0] note_count;
    logic                   note_dropped;

    arrow_note_queue #(.DEPTH(DEPTH), .MAX_ARROWS(MAXA)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .random       (random),
        .enable       (enable),
        .note_pop     (note_pop),
        .note_valid   (note_valid),
        .note_arrows  (note_arrows),
        .note_count   (note_count),
        .note_dropped (note_dropped)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q [$];
    int         mocc;
    logic [3:0] mlast;
    bit         push_phase;
    int         pop_pct;
    logic       s_dropped, s_valid;
    logic [3:0] s_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: whenever the DUT shows a head, it must be the oldest accepted chord.
    always @(negedge clk) begin
        if (reset_n) begin
            if (note_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head_unexpected: got %0h expected none", note_arrows);
                end else begin
                    check("head", note_arrows, exp_q[0]);
                    if (note_pop) void'(exp_q.pop_front());
                end
            end else begin
                check("empty_arrows", note_arrows, 0);
            end
        end
    end

    function automatic logic rp();
        return ($urandom_range(0, 99) < pop_pct);
    endfunction

    // One clock: drive inputs, sample at negedge, advance the occupancy model at posedge.
    task automatic step(input logic en, input logic b, input logic pop, input logic exp_drop);
        logic pop_eff, wr;
        enable   = en;
        random   = b;
        note_pop = pop;
        @(negedge clk);
        s_dropped = note_dropped;
        s_count   = note_count;
        s_valid   = note_valid;
        check("count", s_count, mocc);
        check("valid", s_valid, mocc != 0);
        check("dropped", s_dropped, exp_drop);
        @(posedge clk);
        pop_eff = pop && (mocc > 0);
        wr      = push_phase && ((mocc < DEPTH) || pop_eff);
        if (wr) push_phase = 0;
        mocc = mocc + int'(wr) - int'(pop_eff);
        #1;
    endtask

    task automatic send_chord(input logic [3:0] c, input int freeze);
        bit acc;
        int n;
        acc = ($countones(c) <= MAXA) && !((c != 4'd0) && (c == mlast));
        step(1'b1, c[3], rp(), 1'b0);
        step(1'b1, c[2], rp(), 1'b0);
        repeat (freeze) step(1'b0, 1'($urandom), rp(), 1'b0);
        step(1'b1, c[1], rp(), 1'b0);
        step(1'b1, c[0], rp(), 1'b0);
        step(1'b1, 1'($urandom), rp(), !acc);
        if (acc) begin
            exp_q.push_back(c);
            if (c != 4'd0) mlast = c;
            push_phase = 1;
            n = 0;
            while (push_phase && n < 50) begin
                step(1'b1, 1'($urandom), (n >= 5) ? 1'b1 : rp(), 1'b0);
                n++;
            end
            if (push_phase) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got stalled expected write");
                push_phase = 0;
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        mocc       = 0;
        mlast      = 4'd0;
        push_phase = 0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        note_pop = 1'b0;
        clear_model();
        #1;
        check("rst_valid", note_valid, 0);
        check("rst_count", note_count, 0);
        check("rst_arrows", note_arrows, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mocc > 0 && n < 64) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check("drain_sb", exp_q.size(), 0);
        check("drain_count", note_count, 0);
    endtask

    initial begin
        logic [3:0] seq_full [9];
        logic [3:0] c;
        int         r;
        clk      = 1'b0;
        random   = 1'b0;
        pop_pct  = 0;
        seq_full = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                     4'b0101, 4'b0110, 4'b1001, 4'b1010};
        do_reset();

        send_chord(4'b1010, 0);
        check("basic_count", note_count, 1);
        check("basic_head", note_arrows, 4'b1010);
        check("basic_valid", note_valid, 1);
        send_chord(4'b1110, 0);
        check("toomany_count", note_count, 1);
        send_chord(4'b0101, 0);
        check("after_drop_count", note_count, 2);
        drain();

        do_reset();
        send_chord(4'b1010, 0);
        send_chord(4'b1010, 0);
        send_chord(4'b0000, 0);
        send_chord(4'b0000, 0);
        send_chord(4'b1010, 0);
        check("rest_count", note_count, 3);
        drain();

        do_reset();
        for (int i = 0; i < 8; i++) send_chord(seq_full[i], 0);
        check("full_count", note_count, 8);
        send_chord(seq_full[8], 0);
        check("stall_count", note_count, 8);
        check("stall_head", note_arrows, 4'b0010);
        drain();

        do_reset();
        send_chord(4'b1100, 10);
        check("freeze_head", note_arrows, 4'b1100);
        check("freeze_count", note_count, 1);
        drain();

        do_reset();
        send_chord(4'b0011, 0);
        send_chord(4'b0101, 0);
        send_chord(4'b0110, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", note_valid, 0);
        check("async_count", note_count, 0);
        check("async_arrows", note_arrows, 0);
        clear_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_chord(4'b0110, 0);
        check("fresh_count", note_count, 1);
        check("fresh_head", note_arrows, 4'b0110);
        drain();

        do_reset();
        pop_pct = 40;
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 2)      c = mlast;
            else if (r < 3) c = 4'd0;
            else            c = 4'($urandom_range(0, 15));
            send_chord(c, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
